// File: rtl/seq_alu_pkg.sv
// Shared types and latency constants for the sequential ALU.
package seq_alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int MUL_CYCLES = ALU_WIDTH / 2;
    localparam int DIV_CYCLES = ALU_WIDTH + 1;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_NEG    = 4'b0010,
        OP_NOT    = 4'b0011,
        OP_ADD    = 4'b0100,
        OP_SUB    = 4'b0101,
        OP_MUL    = 4'b0110,
        OP_DIV    = 4'b0111,
        OP_SHR    = 4'b1000,
        OP_SHRA   = 4'b1001,
        OP_SHL    = 4'b1010,
        OP_ROR    = 4'b1011,
        OP_ROL    = 4'b1100,
        OP_INCPC  = 4'b1101,
        OP_BRANCH = 4'b1110,
        OP_RSVD   = 4'b1111
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } alu_state_t;

endpackage

// File: rtl/seq_alu_booth.sv
// One radix-4 Booth iteration: selects 0/+-M/+-2M from a bit triplet and accumulates it.
module booth_r4_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [2:0]         bits,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        case (bits)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = {mcand[2*WIDTH-2:0], 1'b0};
            3'b100:         pp = -{mcand[2*WIDTH-2:0], 1'b0};
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        acc_next = acc + pp;
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake, Booth multiplier and optional
// non-restoring divider (enabled by defining ALU_DIV_EN).
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] c,
    output logic               div_by_zero,
    output logic               illegal_op
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);

    alu_state_t         state, state_nxt;
    alu_op_t            op_in, op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
    logic [WIDTH-1:0]   mplr;
    logic               mplr_prev;

    assign op_in = alu_op_t'(op);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MUL:  state_nxt = ST_MUL;
`ifdef ALU_DIV_EN
                        OP_DIV:  state_nxt = (b == '0) ? ST_DONE : ST_DIV;
`endif
                        default: state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_MUL: if (cnt == MUL_LAST) state_nxt = ST_DONE;
`ifdef ALU_DIV_EN
            ST_DIV: if (cnt == CW'(WIDTH - 1)) state_nxt = ST_FIX;
            ST_FIX: state_nxt = ST_DONE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    booth_r4_step #(.WIDTH(WIDTH)) u_booth (
        .acc      (acc),
        .mcand    (mcand),
        .bits     ({mplr[1:0], mplr_prev}),
        .acc_next (acc_nxt)
    );

    // Multiplicand walks left and multiplier walks right two bits per Booth digit.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q      <= OP_AND;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            mplr_prev <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op_in;
                        a_q       <= a;
                        b_q       <= b;
                        cnt       <= '0;
                        acc       <= '0;
                        mcand     <= {{WIDTH{a[WIDTH-1]}}, a};
                        mplr      <= b;
                        mplr_prev <= 1'b0;
                    end
                end
                ST_MUL: begin
                    acc       <= acc_nxt;
                    mcand     <= {mcand[2*WIDTH-3:0], 2'b00};
                    mplr      <= {2'b00, mplr[WIDTH-1:2]};
                    mplr_prev <= mplr[1];
                    cnt       <= cnt + CW'(1);
                end
                ST_DIV: cnt <= cnt + CW'(1);
                default: ;
            endcase
        end
    end

`ifdef ALU_DIV_EN
    logic [WIDTH+1:0]   rem, rem_sh, rem_nxt;
    logic [WIDTH-1:0]   quo, dvs, rem_fix, quo_out, rem_out;
    logic [2*WIDTH-1:0] div_res;

    always_comb begin
        rem_sh  = {rem[WIDTH:0], quo[WIDTH-1]};
        rem_nxt = rem[WIDTH+1] ? rem_sh + {2'b00, dvs} : rem_sh - {2'b00, dvs};
        rem_fix = rem[WIDTH-1:0] + (rem[WIDTH+1] ? dvs : '0);
        quo_out = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo : quo;
        rem_out = a_q[WIDTH-1] ? -rem_fix : rem_fix;
    end

    // Magnitudes are divided unsigned; signs are reapplied in FIX.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            div_res <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem <= '0;
                        quo <= a[WIDTH-1] ? -a : a;
                        dvs <= b[WIDTH-1] ? -b : b;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
                end
                ST_FIX: div_res <= {rem_out, quo_out};
                default: ;
            endcase
        end
    end
`endif

    logic [SW-1:0]      sh;
    logic [SW:0]        rol_sh;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] result;
    logic               wide, res_dbz, res_ill;

    always_comb begin
        sh      = b_q[SW-1:0];
        rol_sh  = (SW+1)'(WIDTH) - {1'b0, sh};
        lo      = '0;
        wide    = 1'b0;
        result  = '0;
        res_dbz = 1'b0;
        res_ill = 1'b0;
        case (op_q)
            OP_AND:            lo = a_q & b_q;
            OP_OR:             lo = a_q | b_q;
            OP_NEG:            lo = -a_q;
            OP_NOT:            lo = ~a_q;
            OP_ADD, OP_BRANCH: lo = a_q + b_q;
            OP_SUB:            lo = a_q - b_q;
            OP_MUL: begin
                wide   = 1'b1;
                result = acc;
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                wide = 1'b1;
                if (b_q == '0) begin
                    res_dbz = 1'b1;
                    result  = {a_q, {WIDTH{1'b1}}};
                end else begin
                    result  = div_res;
                end
`else
                res_ill = 1'b1;
`endif
            end
            OP_SHR:            lo = a_q >> sh;
            OP_SHRA:           lo = $signed(a_q) >>> sh;
            OP_SHL:            lo = a_q << sh;
            OP_ROR:            lo = WIDTH'({a_q, a_q} >> sh);
            OP_ROL:            lo = WIDTH'({a_q, a_q} >> rol_sh);
            OP_INCPC:          lo = b_q + WIDTH'(1);
            default:           res_ill = 1'b1;
        endcase
        if (!wide) result = {{WIDTH{1'b0}}, lo};
    end

    // Every output is a flop; results only move on the DONE cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            c           <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            busy <= (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
            done <= (state == ST_DONE);
            if (state == ST_DONE) begin
                c           <= result;
                div_by_zero <= res_dbz;
                illegal_op  <= res_ill;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH = 32); tracks ALU_DIV_EN the same way the design does.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero, illegal_op;
    logic [63:0] c;

    int n_checks = 0;
    int n_pass = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .c           (c),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    // Reference behaviour written directly from the arithmetic definitions.
    function automatic void model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [63:0] r, output logic dz, output logic il,
                                     output int lat);
        logic [31:0] v;
        longint sx, sy, q, rm, p;
        int sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        v = '0;
        r = '0;
        dz = 1'b0;
        il = 1'b0;
        lat = 1;
        case (o)
            4'd0: v = x & y;
            4'd1: v = x | y;
            4'd2: v = 32'd0 - x;
            4'd3: v = ~x;
            4'd4, 4'd14: v = x + y;
            4'd5: v = x - y;
            4'd13: v = y + 32'd1;
            4'd8: begin v = x; for (int i = 0; i < sh; i++) v = {1'b0, v[31:1]}; end
            4'd9: begin v = x; for (int i = 0; i < sh; i++) v = {v[31], v[31:1]}; end
            4'd10: begin v = x; for (int i = 0; i < sh; i++) v = {v[30:0], 1'b0}; end
            4'd11: begin v = x; for (int i = 0; i < sh; i++) v = {v[0], v[31:1]}; end
            4'd12: begin v = x; for (int i = 0; i < sh; i++) v = {v[30:0], v[31]}; end
            default: ;
        endcase
        r = {32'd0, v};
        if (o == 4'd6) begin
            p = sx * sy;
            r = p;
            lat = MUL_CYCLES + 1;
        end else if (o == 4'd7) begin
`ifdef ALU_DIV_EN
            if (y == 32'd0) begin
                dz = 1'b1;
                r = {x, 32'hFFFF_FFFF};
            end else begin
                q = sx / sy;
                rm = sx % sy;
                r = {rm[31:0], q[31:0]};
                lat = DIV_CYCLES + 1;
            end
`else
            il = 1'b1;
            r = '0;
`endif
        end else if (o == 4'd15) begin
            il = 1'b1;
            r = '0;
        end
    endfunction

    logic [63:0] exp_c = '0, pend_c = '0;
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_dz = 1'b0, exp_il = 1'b0;
    logic        pend_dz = 1'b0, pend_il = 1'b0;
    bit          active = 1'b0;
    int          cyc = 0, pend_lat = 1;

    // Model: one op in flight, results appear exactly at its latency.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            active = 1'b0;
            cyc = 0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_c = '0;
            exp_dz = 1'b0;
            exp_il = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (active) begin
                cyc++;
                if (cyc == pend_lat) begin
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                    exp_c = pend_c;
                    exp_dz = pend_dz;
                    exp_il = pend_il;
                    active = 1'b0;
                end else begin
                    exp_busy = 1'b1;
                end
            end else if (start) begin
                model_op(op, a, b, pend_c, pend_dz, pend_il, pend_lat);
                active = 1'b1;
                cyc = 0;
                exp_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check_output("cyc_busy", 64'(busy), 64'(exp_busy));
        check_output("cyc_done", 64'(done), 64'(exp_done));
        check_output("cyc_c", c, exp_c);
        if (exp_done) begin
            check_output("cyc_dz", 64'(div_by_zero), 64'(exp_dz));
            check_output("cyc_ill", 64'(illegal_op), 64'(exp_il));
        end
    end

    task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #2;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] ec, input int elat, input logic edz, input logic eil);
        int k = 0;
        int nbusy = 0;
        bit seen = 1'b0;
        apply_stimulus(o, x, y);
        while (!seen && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("[TB] FAIL %s_timeout: got no done, want done in cycle %0d", name, elat);
        end else begin
            check_output({name, "_c"}, c, ec);
            check_output({name, "_lat"}, 64'(k), 64'(elat));
            check_output({name, "_busy"}, 64'(nbusy), 64'(elat - 1));
            check_output({name, "_dz"}, 64'(div_by_zero), 64'(edz));
            check_output({name, "_ill"}, 64'(illegal_op), 64'(eil));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int ndone;
        bit seen;
        @(negedge clk);
        check_output("rst_c", c, 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);
        #12 clr_n = 1'b1;

        run_op("and",    4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1, 1'b0, 1'b0);
        run_op("or",     4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_FFF0FFF0, 1, 1'b0, 1'b0);
        run_op("neg",    4'd2,  32'h00000001, 32'h0,        64'h00000000_FFFFFFFF, 1, 1'b0, 1'b0);
        run_op("not",    4'd3,  32'h0000FFFF, 32'h0,        64'h00000000_FFFF0000, 1, 1'b0, 1'b0);
        run_op("add",    4'd4,  32'd3,        32'd4,        64'h00000000_00000007, 1, 1'b0, 1'b0);
        run_op("sub",    4'd5,  32'd3,        32'd4,        64'h00000000_FFFFFFFF, 1, 1'b0, 1'b0);
        run_op("mul",    4'd6,  32'hFFFFFFF9, 32'd6,        64'hFFFFFFFF_FFFFFFD6, 17, 1'b0, 1'b0);
        run_op("mulmin", 4'd6,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 17, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
        run_op("div",    4'd7,  32'hFFFFFFEF, 32'd5,        64'hFFFFFFFE_FFFFFFFD, 34, 1'b0, 1'b0);
        run_op("divneg", 4'd7,  32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0, 1'b0);
        run_op("divmin", 4'd7,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0, 1'b0);
        run_op("divz",   4'd7,  32'h12345678, 32'd0,        64'h12345678_FFFFFFFF, 1, 1'b1, 1'b0);
`else
        run_op("div",    4'd7,  32'hFFFFFFEF, 32'd5,        64'd0, 1, 1'b0, 1'b1);
        run_op("divz",   4'd7,  32'h12345678, 32'd0,        64'd0, 1, 1'b0, 1'b1);
`endif
        run_op("shr",    4'd8,  32'h80000000, 32'd31,       64'h00000000_00000001, 1, 1'b0, 1'b0);
        run_op("shra",   4'd9,  32'h80000001, 32'd4,        64'h00000000_F8000000, 1, 1'b0, 1'b0);
        run_op("shra0",  4'd9,  32'h80000001, 32'd32,       64'h00000000_80000001, 1, 1'b0, 1'b0);
        run_op("shl",    4'd10, 32'h00000001, 32'd31,       64'h00000000_80000000, 1, 1'b0, 1'b0);
        run_op("ror",    4'd11, 32'h80000001, 32'd36,       64'h00000000_18000000, 1, 1'b0, 1'b0);
        run_op("rol",    4'd12, 32'h80000001, 32'd1,        64'h00000000_00000003, 1, 1'b0, 1'b0);
        run_op("incpc",  4'd13, 32'd5,        32'hFFFFFFFF, 64'h00000000_00000000, 1, 1'b0, 1'b0);
        run_op("branch", 4'd14, 32'd1,        32'd2,        64'h00000000_00000003, 1, 1'b0, 1'b0);
        run_op("rsvd",   4'd15, 32'd1,        32'd2,        64'd0, 1, 1'b0, 1'b1);

        // A MUL start arriving mid-DIV must be dropped.
        apply_stimulus(4'd7, 32'hFFFFFFEF, 32'd5);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(posedge clk);
            k++;
            if (k == 5) begin #2; start = 1'b1; op = 4'd6; a = 32'd2; b = 32'd3; end
            if (k == 6) begin #2; start = 1'b0; end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
`ifdef ALU_DIV_EN
        check_output("ign_lat", 64'(k), 64'd34);
        check_output("ign_c", c, 64'hFFFFFFFE_FFFFFFFD);
`else
        check_output("ign_lat", 64'(k), 64'd1);
        check_output("ign_c", c, 64'd0);
`endif
        repeat (40) @(posedge clk);

        // Reset in cycle 8 of a MUL aborts it with no done pulse.
        apply_stimulus(4'd6, 32'd5, 32'd7);
        repeat (8) @(posedge clk);
        #2 clr_n = 1'b0;
        @(negedge clk);
        check_output("abort_c", c, 64'd0);
        check_output("abort_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #2 clr_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_output("abort_nodone", 64'(ndone), 64'd0);
        run_op("addrst", 4'd4, 32'd3, 32'd4, 64'h00000000_00000007, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
